// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the elastic pipeline register chain
package pipe_pkg;
  localparam int PIPE_MAX_DEPTH = 8;
  function automatic int cnt_width(input int depth, input int skid);
    return $clog2(depth * (skid + 1) + 1);
  endfunction
endpackage

// File: rtl/pipe_reg_chain_slot.sv
// pipe_slot: one valid/ready stage, either single-entry or main+skid with registered ready
module pipe_slot #(
  parameter int DATAWIDTH = 32,
  parameter int SKID      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [DATAWIDTH-1:0] up_d,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [DATAWIDTH-1:0] dn_d
);
  if (SKID != 0) begin : g_skid
    logic                 m_v, s_v;
    logic [DATAWIDTH-1:0] m_d, s_d;
    logic                 main_free;
    assign main_free = !m_v || dn_ready;
    assign up_ready  = !s_v;
    assign dn_valid  = m_v;
    assign dn_d      = m_d;
    // skid refills main first; otherwise a free main takes input and a stalled main parks it in skid
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_d <= '0;
        s_d <= '0;
      end else if (flush_i) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_d <= '0;
        s_d <= '0;
      end else if (s_v) begin
        if (dn_ready) begin
          m_d <= s_d;
          s_v <= 1'b0;
        end
      end else if (main_free) begin
        m_v <= up_valid;
        if (up_valid) m_d <= up_d;
      end else if (up_valid) begin
        s_v <= 1'b1;
        s_d <= up_d;
      end
  end else begin : g_plain
    logic                 v_q;
    logic [DATAWIDTH-1:0] d_q;
    assign up_ready = !v_q || dn_ready;
    assign dn_valid = v_q;
    assign dn_d     = d_q;
    // single entry: load when free or draining, empty out when drained with nothing behind
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush_i) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (up_valid && up_ready) begin
        v_q <= 1'b1;
        d_q <= up_d;
      end else if (dn_ready) begin
        v_q <= 1'b0;
      end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH chained handshake stages with flush and an occupancy counter
module pipe_reg_chain import pipe_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 2,
  parameter int SKID      = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [DATAWIDTH-1:0]                d_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [DATAWIDTH-1:0]                q_o,
  output logic [cnt_width(DEPTH, SKID)-1:0]   count_o
);
  localparam int CW = cnt_width(DEPTH, SKID);
  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH || (SKID != 0 && SKID != 1)) begin : g_bad_cfg
    $fatal(1, "pipe_reg_chain: DEPTH must be 1..%0d and SKID 0 or 1", PIPE_MAX_DEPTH);
  end
  logic [DEPTH:0]       v, r;
  logic [DATAWIDTH-1:0] d [DEPTH+1];
  logic [CW-1:0]        count_q;
  logic                 xfer_in, xfer_out;
  assign v[0]     = valid_i;
  assign d[0]     = d_i;
  assign r[DEPTH] = ready_i;
  assign ready_o  = r[0];
  assign valid_o  = v[DEPTH];
  assign q_o      = d[DEPTH];
  assign count_o  = count_q;
  assign xfer_in  = valid_i && r[0];
  assign xfer_out = v[DEPTH] && ready_i;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_slot #(.DATAWIDTH(DATAWIDTH), .SKID(SKID)) u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .up_valid (v[k]),
      .up_ready (r[k]),
      .up_d     (d[k]),
      .dn_valid (v[k+1]),
      .dn_ready (r[k+1]),
      .dn_d     (d[k+1])
    );
  end
  // occupancy tracks accepted minus delivered words; flush empties the chain
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= '0;
    else if (flush_i) count_q <= '0;
    else if (xfer_in && !xfer_out) count_q <= count_q + CW'(1);
    else if (xfer_out && !xfer_in) count_q <= count_q - CW'(1);
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed stimulus on SKID=0 and SKID=1 chains with a FIFO/age reference model
module tb_pipe_reg_chain;
  localparam int DEPTH = 2;
  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, valid_i, ready_i;
  logic [31:0] d_i;
  logic        r0, v0, r1, v1;
  logic [31:0] q0, q1;
  logic [1:0]  c0;
  logic [2:0]  c1;
  int          total = 0, bad = 0;
  logic [31:0] md [2][64];
  int          mc [2][64];
  int          hd [2], tl [2];
  int          edges = 0;

  always #5 clk_i = ~clk_i;

  pipe_reg_chain #(.DATAWIDTH(32), .DEPTH(DEPTH), .SKID(0)) u_s0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r0),
    .d_i(d_i), .valid_o(v0), .ready_i(ready_i), .q_o(q0), .count_o(c0));
  pipe_reg_chain #(.DATAWIDTH(32), .DEPTH(DEPTH), .SKID(1)) u_s1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r1),
    .d_i(d_i), .valid_o(v1), .ready_i(ready_i), .q_o(q1), .count_o(c1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: each chain is a FIFO of words stamped with their capture edge. The oldest word
  // advances one stage per edge, so it is visible once DEPTH-1 edges have passed since capture.
  always @(negedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      logic        ro, vo, ev;
      logic [31:0] qo;
      int          co, n;
      ro = (i == 1) ? r1 : r0;
      vo = (i == 1) ? v1 : v0;
      qo = (i == 1) ? q1 : q0;
      co = (i == 1) ? int'(c1) : int'(c0);
      n  = tl[i] - hd[i];
      if (!rst_ni) begin
        hd[i] = 0;
        tl[i] = 0;
        chk($sformatf("rst_valid%0d", i), vo, 0);
        chk($sformatf("rst_count%0d", i), co, 0);
      end else begin
        ev = (n > 0) && (edges - mc[i][hd[i] % 64] >= DEPTH - 1);
        chk($sformatf("valid_o%0d", i), vo, ev);
        if (ev) chk($sformatf("q_o%0d", i), qo, md[i][hd[i] % 64]);
        chk($sformatf("count_o%0d", i), co, n);
        if (i == 0) chk("ready_o0", ro, (n < DEPTH) || ready_i);
        else if (n == 2 * DEPTH) chk("ready_full1", ro, 0);
        else if (n < DEPTH) chk("ready_free1", ro, 1);
        if (flush_i) hd[i] = tl[i];
        else begin
          if (ev && ready_i) hd[i]++;
          if (valid_i && ro) begin
            md[i][tl[i] % 64] = d_i;
            mc[i][tl[i] % 64] = edges + 1;
            tl[i]++;
          end
        end
      end
    end
    edges++;
  end

  initial begin
    int          idx, got;
    logic        acc, sent, seen;
    logic [31:0] sq;
    logic [31:0] outs [6];
    hd[0] = 0; hd[1] = 0; tl[0] = 0; tl[1] = 0;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; d_i = '0;
    repeat (3) step();
    chk("reset_valid", v1, 0);
    chk("reset_q", q1, 0);
    chk("reset_count", c1, 0);
    rst_ni = 1'b1;
    #1;
    chk("idle_ready_s1", r1, 1);
    chk("idle_ready_s0", r0, 1);

    ready_i = 1'b1; valid_i = 1'b1; d_i = 32'h11;
    step();
    chk("stream_latency", v0, 0);
    d_i = 32'h22;
    step();
    chk("stream_v_first", v0, 1);
    chk("stream_q_11", q0, 32'h11);
    d_i = 32'h33;
    step();
    chk("stream_q_22", q0, 32'h22);
    chk("stream_count", c0, 2);
    valid_i = 1'b0;
    step();
    chk("stream_q_33", q0, 32'h33);
    step();
    chk("stream_drained", v0, 0);

    ready_i = 1'b0; valid_i = 1'b1; idx = 0;
    for (int k = 0; k < 8; k++) begin
      d_i = 32'hA0 + idx;
      acc = r1;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready", r1, 0);
    chk("bp_count", c1, 4);
    ready_i = 1'b1; got = 0;
    for (int k = 0; k < 20 && got < 6; k++) begin
      valid_i = idx < 6;
      d_i = 32'hA0 + idx;
      acc = r1 && valid_i;
      sent = v1;
      sq = q1;
      step();
      if (acc) idx++;
      if (sent) begin
        outs[got] = sq;
        got++;
      end
    end
    valid_i = 1'b0;
    chk("bp_drain_count", got, 6);
    for (int j = 0; j < 6; j++) chk($sformatf("bp_order%0d", j), outs[j], 32'hA0 + j);

    ready_i = 1'b0; valid_i = 1'b1; idx = 0;
    for (int k = 0; k < 10 && c1 != 3'd4; k++) begin
      d_i = 32'hB0 + idx;
      acc = r1;
      step();
      if (acc) idx++;
    end
    chk("full_count", c1, 4);
    ready_i = 1'b1; d_i = 32'hBF;
    step();
    ready_i = 1'b0; valid_i = 1'b0;
    chk("pulse_count", c1, 3);
    chk("pulse_next_q", q1, 32'hB1);

    flush_i = 1'b1; valid_i = 1'b1; d_i = 32'h55;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_count", c1, 0);
    chk("flush_valid", v1, 0);
    chk("flush_q", q1, 0);
    chk("flush_count_s0", c0, 0);
    ready_i = 1'b1; seen = 1'b0;
    repeat (5) begin
      if ((v1 && q1 == 32'h55) || (v0 && q0 == 32'h55)) seen = 1'b1;
      step();
    end
    chk("flush_discard", seen, 0);

    ready_i = 1'b0; valid_i = 1'b1;
    for (int k = 0; k < 10 && c1 != 3'd3; k++) begin
      d_i = 32'hC0 + k;
      step();
    end
    valid_i = 1'b0;
    chk("pre_rst_count", c1, 3);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_count", c1, 0);
    chk("async_rst_valid", v1, 0);
    chk("async_rst_q", q1, 0);
    step();
    rst_ni = 1'b1;
    ready_i = 1'b1; valid_i = 1'b1; d_i = 32'h77;
    step();
    valid_i = 1'b0;
    chk("post_rst_latency", v1, 0);
    step();
    chk("post_rst_valid", v1, 1);
    chk("post_rst_q", q1, 32'h77);
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
